// File: rtl/pcore_if_pkg.sv
// -----------------------------------------------------------------------------
// pcore_if_pkg
// Shared pcore interface definitions: default magic addresses used by the
// test harness and the signature capture state type, plus the saturating
// counter helper used by the capture block.
// -----------------------------------------------------------------------------
package pcore_if_pkg;

  // Word addresses the core writes to emit signature data / request end of test.
  localparam logic [31:0] DEFAULT_SIG_ADDR  = 32'h8E00_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h8F00_0000;

  localparam logic [15:0] SIG_COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,  // capturing signature writes
    ST_DRAIN  = 2'd1,  // halt requested, waiting for the buffer to empty
    ST_HALTED = 2'd2   // test complete, everything discarded until reset
  } cap_state_e;

  // Increment that sticks at the maximum instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == SIG_COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/sig_capture_unit_fifo.sv
// -----------------------------------------------------------------------------
// sig_fifo
// Signature word buffer. Pointers carry one extra wrap bit so that full and
// empty are told apart without a separate occupancy counter. The head word is
// read straight from the storage registers, so it appears the cycle after a
// push into an empty buffer.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   push_i, data_i  write a word (ignored when full)
//   pop_i           remove the head word (ignored when empty)
//   data_o          head word
//   full_o, empty_o occupancy flags
//   count_o         current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sig_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,                // power of two, at least 2
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Same index bits with opposite wrap bits means the writer is a full lap ahead.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves a value unassigned and no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_i;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage is reset along with the pointers so the head word reads
  // as zero out of reset; that is only affordable because the buffer is tiny.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/sig_capture_unit.sv
// -----------------------------------------------------------------------------
// sig_capture_unit
// Snoops the core data bus for writes to two magic addresses. Writes to
// SIG_ADDR are buffered as signature words for a downstream consumer; a write
// to HALT_ADDR ends the test once every buffered word has been drained.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   req_valid_i    bus request valid
//   req_we_i       request is a write
//   req_addr_i     request byte address
//   req_wdata_i    write data
//   req_ready_o    request accepted this cycle (only ever low for a signature
//                  write that cannot be buffered)
//   sig_valid_o    signature word available
//   sig_data_o     head signature word
//   sig_ready_i    consumer takes the head word
//   halt_o         test complete and buffer drained, held until reset
//   sig_count_o    signature words accepted since reset, saturating
// -----------------------------------------------------------------------------
module sig_capture_unit
  import pcore_if_pkg::*;
#(
  parameter logic [31:0] SIG_ADDR   = DEFAULT_SIG_ADDR,
  parameter logic [31:0] HALT_ADDR  = DEFAULT_HALT_ADDR,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        sig_valid_o,
  output logic [31:0] sig_data_o,
  input  logic        sig_ready_i,
  output logic        halt_o,
  output logic [15:0] sig_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  cap_state_e  state_q, state_d;
  logic [15:0] count_q, count_d;

  logic        sig_hit;
  logic        halt_hit;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;

  assign sig_hit  = req_valid_i & req_we_i & (req_addr_i == SIG_ADDR);
  assign halt_hit = req_valid_i & req_we_i & (req_addr_i == HALT_ADDR);

  assign sig_valid_o = ~fifo_empty;
  assign pop         = sig_valid_o & sig_ready_i;
  assign halt_o      = (state_q == ST_HALTED);
  assign sig_count_o = count_q;

  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    req_ready_o = 1'b1;
    unique case (state_q)
      ST_RUN: begin
        if (sig_hit) begin
          // A full buffer stalls the writer; a pop this cycle does not free
          // the slot until the next one.
          req_ready_o = ~fifo_full;
          push        = ~fifo_full;
        end else if (halt_hit) begin
          // Skip DRAIN when nothing will be left after this edge.
          if (fifo_empty || (fifo_count == (AW+1)'(1) && pop)) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (sig_hit) begin
          req_ready_o = 1'b0;
        end
        if (fifo_empty) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        // Everything accepted and dropped.
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push) begin
      count_d = sat_inc16(count_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  sig_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_sig_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (req_wdata_i),
    .pop_i   (pop),
    .data_o  (sig_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_sig_capture_unit.sv
// -----------------------------------------------------------------------------
// tb_sig_capture_unit
// Directed scenarios plus randomized traffic for sig_capture_unit, checked
// against a queue-based model of the capture rules.
// -----------------------------------------------------------------------------
module tb_sig_capture_unit;

  localparam logic [31:0] SIG_A  = 32'h8E00_0000;
  localparam logic [31:0] HALT_A = 32'h8F00_0000;
  localparam int          DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_ready_o;
  logic        sig_valid_o;
  logic [31:0] sig_data_o;
  logic        sig_ready_i;
  logic        halt_o;
  logic [15:0] sig_count_o;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered words, halt bookkeeping, accepted count.
  logic [31:0] m_q[$];
  bit          m_halt_req;
  bit          m_halted;
  int          m_count;

  sig_capture_unit #(
    .SIG_ADDR   (SIG_A),
    .HALT_ADDR  (HALT_A),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .sig_valid_o (sig_valid_o),
    .sig_data_o  (sig_data_o),
    .sig_ready_i (sig_ready_i),
    .halt_o      (halt_o),
    .sig_count_o (sig_count_o)
  );

  always #5 clk = ~clk;

  function automatic bit is_sig_hit();
    return req_valid_i && req_we_i && (req_addr_i == SIG_A);
  endfunction

  function automatic bit is_halt_hit();
    return req_valid_i && req_we_i && (req_addr_i == HALT_A);
  endfunction

  function automatic logic exp_ready();
    if (!is_sig_hit()) return 1'b1;
    if (m_halted)      return 1'b1;
    if (m_halt_req)    return 1'b0;
    return (m_q.size() < DEPTH);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_halt_req = 0;
    m_halted   = 0;
    m_count    = 0;
  endtask

  // Drive one cycle of inputs after the falling edge; outputs settle by #1.
  task automatic set_in(input logic v, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic rdy);
    @(negedge clk);
    req_valid_i = v;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    sig_ready_i = rdy;
    #1;
  endtask

  // Advance the model by the rules for the current inputs, then take the edge.
  task automatic tick();
    bit pop, push;
    int sz;
    sz   = m_q.size();
    pop  = (sz > 0) && sig_ready_i;
    push = is_sig_hit() && !m_halt_req && (sz < DEPTH);
    if (!m_halt_req && is_halt_hit()) begin
      m_halt_req = 1;
      if (sz == 0 || (sz == 1 && pop)) m_halted = 1;
    end else if (m_halt_req && !m_halted && sz == 0) begin
      m_halted = 1;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(req_wdata_i);
      if (m_count < 65535) m_count++;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    sig_ready_i = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = SIG_A;
    req_wdata_i = 32'hDEAD_BEEF;
    sig_ready_i = 1'b0;
    model_clear();
    #2;
    checks++;
    if (sig_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", sig_valid_o); end
    checks++;
    if (sig_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", sig_data_o); end
    checks++;
    if (halt_o !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", halt_o); end
    checks++;
    if (sig_count_o !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", sig_count_o); end
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
    @(negedge clk);
    rst         = 1'b0;
    req_valid_i = 1'b0;
  endtask

  task automatic test_in_order();
    logic [31:0] vals[3];
    logic [31:0] got[$];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) set_in(1'b1, 1'b1, SIG_A, vals[i], 1'b1);
      else       set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      if (i < 3) begin
        checks++;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL order_ready[%0d]: got %b expected 1", i, req_ready_o); end
      end
      if (sig_valid_o === 1'b1) got.push_back(sig_data_o);
      tick();
    end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL order_len: got %0d words expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== vals[i]) begin errors++; $display("FAIL order_word[%0d]: got %h expected %h", i, got[i], vals[i]); end
      end
    end
    checks++;
    if (sig_count_o !== 16'd3) begin errors++; $display("FAIL order_count: got %0d expected 3", sig_count_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] wr[9];
    logic [31:0] got[$];
    do_reset();
    for (int i = 0; i < 9; i++) wr[i] = $urandom;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 1'b1, SIG_A, wr[i], 1'b0);
      checks++;
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_fill_ready[%0d]: got %b expected 1", i, req_ready_o); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b1, SIG_A, wr[8], 1'b0);
      checks++;
      if (req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready[%0d]: got %b expected 0", k, req_ready_o); end
      tick();
    end
    checks++;
    if (sig_count_o !== 16'd8) begin errors++; $display("FAIL bp_full_count: got %0d expected 8", sig_count_o); end
    // Pop while the ninth write waits: still stalled this cycle.
    set_in(1'b1, 1'b1, SIG_A, wr[8], 1'b1);
    checks++;
    if (req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_no_bypass: got %b expected 0", req_ready_o); end
    if (sig_valid_o === 1'b1) got.push_back(sig_data_o);
    tick();
    set_in(1'b1, 1'b1, SIG_A, wr[8], 1'b0);
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_after_pop_ready: got %b expected 1", req_ready_o); end
    tick();
    for (int c = 0; c < 20 && got.size() < 9; c++) begin
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      if (sig_valid_o === 1'b1) got.push_back(sig_data_o);
      tick();
    end
    checks++;
    if (got.size() != 9) begin
      errors++; $display("FAIL bp_drain_len: got %0d words expected 9", got.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (got[i] !== wr[i]) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", i, got[i], wr[i]); end
      end
    end
    checks++;
    if (sig_count_o !== 16'd9) begin errors++; $display("FAIL bp_count: got %0d expected 9", sig_count_o); end
  endtask

  task automatic test_drain();
    do_reset();
    set_in(1'b1, 1'b1, SIG_A, 32'hA1, 1'b0); tick();
    set_in(1'b1, 1'b1, SIG_A, 32'hA2, 1'b0); tick();
    set_in(1'b1, 1'b1, HALT_A, 32'h0, 1'b0);
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL drain_halt_ready: got %b expected 1", req_ready_o); end
    tick();
    set_in(1'b1, 1'b1, SIG_A, 32'hA3, 1'b0);
    checks++;
    if (halt_o !== 1'b0) begin errors++; $display("FAIL drain_halt_early: got %b expected 0", halt_o); end
    checks++;
    if (req_ready_o !== 1'b0) begin errors++; $display("FAIL drain_sig_ready: got %b expected 0", req_ready_o); end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (sig_data_o !== 32'hA1) begin errors++; $display("FAIL drain_word0: got %h expected a1", sig_data_o); end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (sig_data_o !== 32'hA2) begin errors++; $display("FAIL drain_word1: got %h expected a2", sig_data_o); end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (sig_valid_o !== 1'b0 || halt_o !== 1'b0) begin
      errors++; $display("FAIL drain_empty_cycle: got valid=%b halt=%b expected 0/0", sig_valid_o, halt_o);
    end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (halt_o !== 1'b1) begin errors++; $display("FAIL drain_halt: got %b expected 1", halt_o); end
    checks++;
    if (sig_count_o !== 16'd2) begin errors++; $display("FAIL drain_count: got %0d expected 2", sig_count_o); end
  endtask

  task automatic test_halt_empty();
    do_reset();
    set_in(1'b1, 1'b1, HALT_A, 32'h0, 1'b0);
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL he_halt_ready: got %b expected 1", req_ready_o); end
    tick();
    set_in(1'b1, 1'b1, SIG_A, 32'h55, 1'b0);
    checks++;
    if (halt_o !== 1'b1) begin errors++; $display("FAIL he_halt: got %b expected 1", halt_o); end
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL he_sig_ready: got %b expected 1", req_ready_o); end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (sig_count_o !== 16'd0 || sig_valid_o !== 1'b0 || halt_o !== 1'b1) begin
      errors++; $display("FAIL he_after: got count=%0d valid=%b halt=%b expected 0/0/1", sig_count_o, sig_valid_o, halt_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, SIG_A, 32'hC0 + i, 1'b0);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sig_valid_o !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", sig_valid_o); end
    checks++;
    if (sig_count_o !== 16'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", sig_count_o); end
    checks++;
    if (halt_o !== 1'b0 || sig_data_o !== 32'h0) begin
      errors++; $display("FAIL rm_halt_data: got halt=%b data=%h expected 0/0", halt_o, sig_data_o);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ignored();
    logic        t_v[5];
    logic        t_we[5];
    logic [31:0] t_a[5];
    t_v[0] = 1; t_we[0] = 1; t_a[0] = 32'h8000_1000;
    t_v[1] = 1; t_we[1] = 0; t_a[1] = SIG_A;
    t_v[2] = 1; t_we[2] = 0; t_a[2] = HALT_A;
    t_v[3] = 0; t_we[3] = 1; t_a[3] = SIG_A;
    t_v[4] = 1; t_we[4] = 1; t_a[4] = SIG_A + 32'd4;
    do_reset();
    set_in(1'b1, 1'b1, SIG_A, 32'h77, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(t_v[i], t_we[i], t_a[i], 32'hFACE_0000 + i, 1'b0);
      checks++;
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL ign_ready[%0d]: got %b expected 1", i, req_ready_o); end
      tick();
    end
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (sig_count_o !== 16'd1 || sig_data_o !== 32'h77 || halt_o !== 1'b0) begin
      errors++; $display("FAIL ign_state: got count=%0d data=%h halt=%b expected 1/77/0", sig_count_o, sig_data_o, halt_o);
    end
    // One word in, one word out: the ignored traffic must not have added any.
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (sig_valid_o !== 1'b0) begin errors++; $display("FAIL ign_no_push: got valid=%b expected 0", sig_valid_o); end
  endtask

  task automatic test_random();
    int          sel;
    logic [31:0] addr;
    for (int ep = 0; ep < 10; ep++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        sel = $urandom_range(0, 99);
        if (sel < 55)      addr = SIG_A;
        else if (sel < 57) addr = HALT_A;
        else               addr = $urandom & 32'hFFFF_FFFC;
        set_in(($urandom_range(0, 9) != 0), ($urandom_range(0, 5) != 0), addr, $urandom,
               ($urandom_range(0, 2) == 0));
        checks++;
        if (req_ready_o !== exp_ready()) begin
          errors++; $display("FAIL rnd_ready[%0d.%0d]: got %b expected %b", ep, c, req_ready_o, exp_ready());
        end
        checks++;
        if (sig_valid_o !== (m_q.size() > 0)) begin
          errors++; $display("FAIL rnd_valid[%0d.%0d]: got %b expected %b", ep, c, sig_valid_o, m_q.size() > 0);
        end
        if (m_q.size() > 0) begin
          checks++;
          if (sig_data_o !== m_q[0]) begin
            errors++; $display("FAIL rnd_data[%0d.%0d]: got %h expected %h", ep, c, sig_data_o, m_q[0]);
          end
        end
        checks++;
        if (halt_o !== m_halted) begin
          errors++; $display("FAIL rnd_halt[%0d.%0d]: got %b expected %b", ep, c, halt_o, m_halted);
        end
        checks++;
        if (sig_count_o !== 16'(m_count)) begin
          errors++; $display("FAIL rnd_count[%0d.%0d]: got %0d expected %0d", ep, c, sig_count_o, m_count);
        end
        tick();
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      set_in(1'b1, 1'b1, SIG_A, i, 1'b1);
      tick();
    end
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (sig_count_o !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", sig_count_o); end
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, SIG_A, i, 1'b1);
      tick();
    end
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (sig_count_o !== 16'hFFFF || m_count != 65535) begin
      errors++; $display("FAIL sat_hold: got %h expected ffff", sig_count_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_backpressure();
    test_drain();
    test_halt_empty();
    test_reset_mid();
    test_ignored();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sig_capture_unit.md
SIG_CAPTURE_UNIT -- requirements
Module: sig_capture_unit

Interface
REQ-001 Parameter SIG_ADDR, default 32'h8E000000, word address whose writes are captured as signature data.
REQ-002 Parameter HALT_ADDR, default 32'h8F000000, word address whose write requests end of test.
REQ-003 Parameter FIFO_DEPTH, default 8, signature buffer depth in words; SHALL be a power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid_i  input  1  data-bus request valid.
REQ-007 req_we_i  input  1  request is a write.
REQ-008 req_addr_i  input  32  request byte address.
REQ-009 req_wdata_i  input  32  write data.
REQ-010 req_ready_o  output  1  request accepted this cycle.
REQ-011 sig_valid_o  output  1  signature word available at head of buffer.
REQ-012 sig_data_o  output  32  signature word at head of buffer.
REQ-013 sig_ready_i  input  1  consumer takes the head word.
REQ-014 halt_o  output  1  test complete; buffer fully drained.
REQ-015 sig_count_o  output  16  signature words accepted since reset, saturating.

Function
REQ-016 A hit is req_valid_i & req_we_i with req_addr_i equal to SIG_ADDR or HALT_ADDR; all other requests are ignored, and req_ready_o SHALL be 1 for them.
REQ-017 States: RUN, DRAIN, HALTED.
REQ-018 In RUN, a SIG_ADDR hit SHALL be accepted (req_ready_o=1) only when the buffer is not full; the word enters the buffer at that clock edge.
REQ-019 When the buffer is full, req_ready_o SHALL be 0 for a SIG_ADDR hit; the request is held, with no same-cycle pop bypass.
REQ-020 A pop occurs when sig_valid_o & sig_ready_i; sig_data_o SHALL be a registered buffer head, valid the cycle after a push into an empty buffer (1-cycle latency).
REQ-021 Simultaneous push and pop on a non-full, non-empty buffer SHALL leave the occupancy unchanged.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-023 A HALT_ADDR hit in RUN SHALL be accepted and move the block to DRAIN if the buffer is non-empty, or to HALTED if it is empty.
REQ-024 A HALT_ADDR hit and a pop of the last word in the same cycle SHALL go directly to HALTED.
REQ-025 DRAIN SHALL move to HALTED on the cycle after the buffer becomes empty; no SIG_ADDR pushes are accepted in DRAIN (req_ready_o=0 for such hits).
REQ-026 In HALTED, all hits SHALL be accepted and discarded; halt_o=1, held until reset.
REQ-027 sig_count_o SHALL increment on each accepted push and saturate at 16'hFFFF.
REQ-028 halt_o SHALL be 0 in RUN and DRAIN.

Reset
REQ-029 On rst: state=RUN, pointers=0, sig_valid_o=0, sig_data_o=0, halt_o=0, sig_count_o=0; req_ready_o follows REQ-016/018 combinationally.
REQ-030 A reset asserted mid-operation SHALL discard buffered words immediately; no partial pop is reported.

Structure
REQ-031 The state enum and the default SIG_ADDR/HALT_ADDR constants SHALL live in the shared pcore interface package.
REQ-032 The buffer SHALL be one sub-module, sig_fifo (parameterised width/depth, push/pop/full/empty), instantiated once.

Verification
REQ-033 Three writes to 8E000000 (11,22,33) with sig_ready_i=1 -> sig_data_o yields 11,22,33 in order; sig_count_o=3.
REQ-034 sig_ready_i=0, nine SIG writes with FIFO_DEPTH=8 -> 9th write sees req_ready_o=0 until one pop, then is accepted; no data lost.
REQ-035 Two words buffered, write to 8F000000 -> state DRAIN, halt_o=0; after two pops, halt_o=1 one cycle later.
REQ-036 HALT write with empty buffer -> halt_o=1 next cycle; a subsequent SIG write is acked, sig_count_o unchanged.
REQ-037 rst pulsed while four words are buffered -> sig_valid_o=0, sig_count_o=0, halt_o=0 immediately.
REQ-038 Writes to 80001000 and reads of 8E000000 -> req_ready_o=1, no push, sig_count_o unchanged.
